// File: rtl/udp_packet_player.sv
// udp_packet_player: buffers one packet of bytes, then replays it as a first/last-framed stream
module udp_packet_player #(
    parameter int DEPTH = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    output logic       udp_rx_valid,
    input  logic       udp_rx_ready,
    output logic       udp_rx_first,
    output logic       udp_rx_last,
    output logic [7:0] udp_rx_payload,
    output logic       udp_rx_last_be,
    output logic       busy,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {FILL, SEND} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   len;
    logic          discard;
    logic          wr_fire, rx_fire, at_end, store, close, trunc, beat_last;

    // Handshakes, framing flags and next state; payload is forced to zero outside SEND
    always_comb begin
        state_next     = state;
        wr_ready       = state == FILL;
        udp_rx_valid   = state == SEND;
        busy           = state == SEND;
        wr_fire        = wr_valid && wr_ready;
        rx_fire        = udp_rx_valid && udp_rx_ready;
        at_end         = wr_ptr == AW'(DEPTH - 1);
        store          = wr_fire && !discard;
        close          = store && (wr_last || at_end);
        trunc          = store && at_end && !wr_last;
        beat_last      = {1'b0, rd_ptr} == len - (AW + 1)'(1);
        udp_rx_first   = udp_rx_valid && rd_ptr == '0;
        udp_rx_last    = udp_rx_valid && beat_last;
        udp_rx_payload = udp_rx_valid ? mem[rd_ptr] : 8'h00;
        udp_rx_last_be = udp_rx_valid;
        if (close)
            state_next = SEND;
        if (rx_fire && beat_last)
            state_next = FILL;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state <= FILL;
        else
            state <= state_next;
    end

    // Pointers, packet length, tail-discard flag and the one-cycle overflow pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len      <= '0;
            discard  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= trunc;
            if (wr_fire && discard && wr_last)
                discard <= 1'b0;
            if (trunc)
                discard <= 1'b1;
            if (store)
                wr_ptr <= wr_ptr + 1'b1;
            if (close) begin
                len    <= {1'b0, wr_ptr} + (AW + 1)'(1);
                rd_ptr <= '0;
            end
            if (rx_fire) begin
                rd_ptr <= beat_last ? '0 : rd_ptr + 1'b1;
                if (beat_last)
                    wr_ptr <= '0;
            end
        end
    end

    // Packet storage; contents need no reset
    always_ff @(posedge clock) begin
        if (store)
            mem[wr_ptr] <= wr_data;
    end
endmodule

// File: tb/tb_udp_packet_player.sv
// tb_udp_packet_player: table-driven packets plus hand sequences, scoreboarded beat by beat
module tb_udp_packet_player;
    localparam int DEPTH = 64;

    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
    } beat_t;

    typedef struct {
        int         n;
        logic [7:0] seed;
        logic [7:0] pat;
        int         beats;
        int         ovf;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       wr_last = 1'b0;
    logic       udp_rx_valid;
    logic       udp_rx_ready = 1'b0;
    logic       udp_rx_first;
    logic       udp_rx_last;
    logic [7:0] udp_rx_payload;
    logic       udp_rx_last_be;
    logic       busy;
    logic       overflow;

    int         checks = 0;
    int         failures = 0;
    int         beats = 0;
    int         ovfs = 0;
    logic       loaded = 1'b0;
    beat_t      exp_q[$];
    beat_t      e;
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [10:0] pd = '0;
    vec_t       tbl[7];

    udp_packet_player #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .udp_rx_valid(udp_rx_valid), .udp_rx_ready(udp_rx_ready),
        .udp_rx_first(udp_rx_first), .udp_rx_last(udp_rx_last),
        .udp_rx_payload(udp_rx_payload), .udp_rx_last_be(udp_rx_last_be),
        .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input logic l);
        int k;
        k = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        while (!wr_ready && k < 5000) begin
            step();
            k++;
        end
        if (k >= 5000) begin
            failures++;
            $display("FAIL wr_ready_timeout waited=%0d", k);
        end
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic load(input int n, input logic [7:0] seed, input logic [7:0] stp, input int lim);
        int m;
        logic [7:0] d;
        m = n < DEPTH ? n : DEPTH;
        loaded = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = seed + 8'(i) * stp;
            if (i < m && i < lim)
                exp_q.push_back('{d, i == 0, i == m - 1});
            put(d, i == n - 1);
        end
        loaded = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 2000) begin
            step();
            k++;
        end
        if (k >= 2000) begin
            failures++;
            $display("FAIL idle_timeout busy=%0b pending=%0d", busy, exp_q.size());
        end
    endtask

    task automatic play(input int n, input logic [7:0] seed, input logic [7:0] pat);
        loaded = 1'b0;
        fork
            load(n, seed, 8'd1, n);
            begin
                int c;
                c = 0;
                while (c < 4000 && !(loaded && !busy)) begin
                    udp_rx_ready = pat[c % 8];
                    step();
                    c++;
                end
                if (c >= 4000) begin
                    failures++;
                    $display("FAIL play_timeout n=%0d", n);
                end
            end
        join
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (reset) begin
            pv = 1'b0;
        end else begin
            if (overflow) begin
                ovfs++;
                chk("ovf_on_first_beat", {30'd0, udp_rx_valid, udp_rx_first}, 32'd3);
            end
            if (pv && !pr)
                chk("stall_stable", {21'd0, udp_rx_valid, udp_rx_payload, udp_rx_first, udp_rx_last}, {21'd0, pd});
            if (udp_rx_valid && udp_rx_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat payload=%0h", udp_rx_payload);
                end else begin
                    e = exp_q.pop_front();
                    chk("payload", {24'd0, udp_rx_payload}, {24'd0, e.data});
                    chk("first", {31'd0, udp_rx_first}, {31'd0, e.first});
                    chk("last", {31'd0, udp_rx_last}, {31'd0, e.last});
                    chk("last_be", {31'd0, udp_rx_last_be}, 32'd1);
                end
            end
            pv = udp_rx_valid;
            pr = udp_rx_ready;
            pd = {udp_rx_valid, udp_rx_payload, udp_rx_first, udp_rx_last};
        end
    end

    initial begin
        int b0, o0;
        logic [6:0] p;
        tbl[0] = '{5,  8'h01, 8'hFF,        5,  0};
        tbl[1] = '{2,  8'h10, 8'b0101_0101, 2,  0};
        tbl[2] = '{64, 8'h20, 8'hFF,        64, 0};
        tbl[3] = '{70, 8'h80, 8'hFF,        64, 1};
        tbl[4] = '{3,  8'hC0, 8'b1011_0010, 3,  0};
        tbl[5] = '{65, 8'h00, 8'b1110_1101, 64, 1};
        tbl[6] = '{1,  8'h3C, 8'b0000_0001, 1,  0};

        repeat (2) step();
        chk("rst_valid", {31'd0, udp_rx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {20'd0, udp_rx_payload, udp_rx_first, udp_rx_last, udp_rx_last_be, overflow}, 32'd0);
        reset = 1'b0;
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

        udp_rx_ready = 1'b1;
        load(3, 8'h11, 8'h11, 3);
        chk("lat_beat0", {22'd0, udp_rx_valid, udp_rx_payload, udp_rx_first}, {22'd0, 1'b1, 8'h11, 1'b1});
        chk("lat_no_ovf", {31'd0, overflow}, 32'd0);
        step();
        chk("lat_beat1", {21'd0, udp_rx_valid, udp_rx_payload, udp_rx_first, udp_rx_last}, {21'd0, 1'b1, 8'h22, 2'b00});
        step();
        chk("lat_beat2", {21'd0, udp_rx_valid, udp_rx_payload, udp_rx_first, udp_rx_last}, {21'd0, 1'b1, 8'h33, 2'b01});
        step();
        chk("lat_done", {30'd0, udp_rx_valid, busy}, 32'd0);

        load(1, 8'hA5, 8'h00, 1);
        chk("single_beat", {21'd0, udp_rx_valid, udp_rx_payload, udp_rx_first, udp_rx_last}, {21'd0, 1'b1, 8'hA5, 2'b11});
        step();
        chk("single_done", {31'd0, udp_rx_valid}, 32'd0);

        udp_rx_ready = 1'b0;
        load(4, 8'h40, 8'h01, 4);
        p = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            udp_rx_ready = p[i];
            step();
        end
        chk("stall_seq_done", {31'd0, udp_rx_valid}, 32'd0);
        chk("stall_seq_drained", exp_q.size(), 32'd0);

        udp_rx_ready = 1'b1;
        load(5, 8'h50, 8'h01, 1);
        chk("rst_mid_beat0", {24'd0, udp_rx_payload}, 32'h50);
        step();
        chk("rst_mid_beat1", {23'd0, udp_rx_valid, udp_rx_payload}, {23'd0, 1'b1, 8'h51});
        reset = 1'b1;
        udp_rx_ready = 1'b0;
        step();
        chk("rst_mid_abort", {20'd0, udp_rx_valid, busy, udp_rx_last, udp_rx_payload, wr_ready}, {20'd0, 3'b000, 8'h00, 1'b1});
        reset = 1'b0;
        play(2, 8'h70, 8'hFF);
        chk("rst_mid_fresh", exp_q.size(), 32'd0);

        udp_rx_ready = 1'b0;
        load(4, 8'h60, 8'h01, 4);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        wr_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("send_wr_ready", {31'd0, wr_ready}, 32'd0);
            step();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        udp_rx_ready = 1'b1;
        wait_idle();

        for (int i = 0; i < 7; i++) begin
            b0 = beats;
            o0 = ovfs;
            play(tbl[i].n, tbl[i].seed, tbl[i].pat);
            chk($sformatf("beats_%0d", i), beats - b0, tbl[i].beats);
            chk($sformatf("ovf_%0d", i), ovfs - o0, tbl[i].ovf);
            chk($sformatf("drained_%0d", i), exp_q.size(), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/udp_packet_player.md
UDP_PACKET_PLAYER -- requirements
Module: udp_packet_player

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the packet buffer capacity in bytes; legal range 2..256, power of two.
REQ-002 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 wr_valid  in  1  SHALL indicate a byte on wr_data is offered for loading.
REQ-005 wr_ready  out  1  SHALL indicate the buffer accepts a byte this cycle.
REQ-006 wr_data  in  8  SHALL carry the byte to load.
REQ-007 wr_last  in  1  SHALL mark the offered byte as the final byte of the packet.
REQ-008 udp_rx_valid  out  1  SHALL indicate a valid stream beat.
REQ-009 udp_rx_ready  in  1  SHALL be the downstream backpressure.
REQ-010 udp_rx_first  out  1  SHALL mark the first beat of a packet.
REQ-011 udp_rx_last  out  1  SHALL mark the last beat of a packet.
REQ-012 udp_rx_payload  out  8  SHALL carry the beat byte.
REQ-013 udp_rx_last_be  out  1  SHALL be the byte-enable of the last beat.
REQ-014 busy  out  1  SHALL be high while a packet is being sent.
REQ-015 overflow  out  1  SHALL pulse for one cycle when a packet is truncated.

Function
REQ-016 The block SHALL have two states, FILL and SEND; FILL is the reset state.
REQ-017 FILL: wr_ready=1, udp_rx_valid=0, busy=0.
REQ-018 FILL: a byte is accepted when wr_valid&wr_ready; it SHALL be stored at wr_ptr, and wr_ptr SHALL increment.
REQ-019 FILL: an accepted byte with wr_last=1 SHALL latch len=wr_ptr+1, clear rd_ptr, and enter SEND on the next cycle.
REQ-020 FILL: an accepted byte at wr_ptr=DEPTH-1 with wr_last=0 SHALL be treated as last (len=DEPTH), enter SEND, and assert overflow for exactly that next cycle.
REQ-021 The bytes the writer offers after a truncation, up to and including its wr_last, SHALL be accepted and discarded without storage once the block returns to FILL; only then SHALL normal loading resume.
REQ-022 SEND: wr_ready=0, busy=1, udp_rx_valid=1, udp_rx_payload=mem[rd_ptr].
REQ-023 udp_rx_first SHALL equal (rd_ptr==0); udp_rx_last SHALL equal (rd_ptr==len-1); a 1-byte packet SHALL assert both on the same beat.
REQ-024 udp_rx_last_be SHALL be 1 whenever udp_rx_valid=1, and 0 otherwise.
REQ-025 A beat transfers when udp_rx_valid&udp_rx_ready; rd_ptr SHALL then increment.
REQ-026 While udp_rx_valid=1 and udp_rx_ready=0, all udp_rx_* outputs SHALL hold stable.
REQ-027 On transfer of the last beat, the block SHALL clear wr_ptr and rd_ptr and return to FILL on the next cycle; udp_rx_valid SHALL be 0 in that cycle.
REQ-028 Zero-length packets SHALL be impossible, because wr_last always accompanies a stored byte.
REQ-029 Pointers SHALL be clog2(DEPTH) bits wide; len SHALL be clog2(DEPTH)+1 bits wide so that it can hold DEPTH.
REQ-030 Latency from an accepted wr_last to the first udp_rx_valid SHALL be exactly 1 cycle.

Reset
REQ-031 While reset=1, at the next edge the block SHALL enter FILL with wr_ptr=0, rd_ptr=0, len=0, the discard flag clear, and udp_rx_valid=0, first=0, last=0, last_be=0, payload=0x00, busy=0, overflow=0.
REQ-032 Reset asserted mid-SEND SHALL abort the packet with no udp_rx_last emitted.
REQ-033 Buffer memory contents SHALL NOT require reset.

Verification
REQ-034 Load 0x11,0x22,0x33 (last on 0x33) with udp_rx_ready=1 held -> beats 0x11(first),0x22,0x33(last) on 3 consecutive cycles starting 1 cycle after wr_last, with last_be=1.
REQ-035 Load the single byte 0xA5 with wr_last -> one beat 0xA5 with first=1, last=1.
REQ-036 Load 4 bytes; toggle udp_rx_ready 1,0,0,1,1,0,1 -> each byte is presented until accepted, outputs are stable while stalled, and the sequence matches the input order.
REQ-037 With DEPTH=64, load 70 bytes (wr_last on the 70th) -> 64 beats, last=1 on byte 64, overflow=1 for one cycle, bytes 65-70 are discarded, and the next packet plays correctly.
REQ-038 Assert reset on the 2nd beat of a 5-byte packet -> udp_rx_valid=0 the next cycle, busy=0, and a fresh packet loads and plays correctly.
REQ-039 Apply wr_valid during SEND -> wr_ready=0, nothing is stored, and the packet in flight is unchanged.
